alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute/write-back pipeline register that sits directly downstream of the combinational alu.
- Captures the alu result and flag outputs and owns the architectural flag register (C, V, Z, S). The C and V flags feed alu cin/vin.
- Sequences multi-cycle (mcp_out) operations by stalling upstream for MCP_EXTRA cycles before capture.
- Presents one registered write-back transaction per instruction to the register file over a valid/ready handshake.

Parameters:
- MCP_EXTRA, 2, extra cycles to wait before capturing a result flagged multi-cycle (valid range 1..15).
- RDEST_W, 4, width of the destination register index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_b  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an instruction with stable alu inputs.
- in_ready  out  1  this stage captures on the current edge when in_valid && in_ready.
- alu_dout  in  32  alu result.
- alu_cout  in  1  alu carry out.
- alu_vout  in  1  alu overflow out.
- alu_qnzout  in  1  alu DJNZ not-zero out.
- alu_mcp  in  1  alu multi-cycle flag (mcp_out).
- rdest  in  RDEST_W  destination register index.
- we_req  in  1  instruction writes rdest.
- flags_en  in  1  instruction updates flags.
- is_djnz  in  1  instruction is DJNZ.
- wb_valid  out  1  write-back transaction pending.
- wb_ready  in  1  register file accepts the transaction.
- wb_data  out  32  registered result.
- wb_rdest  out  RDEST_W  registered destination.
- wb_we  out  1  registered we_req.
- djnz_taken  out  1  registered alu_qnzout && is_djnz, qualified by wb_valid.
- flag_c, flag_v, flag_z, flag_s  out  1 each  architectural flags.
- busy  out  1  high in MCP state.

Behaviour:
- Reset (reset_b low, asynchronous, may occur at any time including mid-MCP or during a held WB):
  - State goes to IDLE, count to 0.
  - wb_valid, wb_data, wb_rdest, wb_we, djnz_taken, all flags and busy are 0.
  - No partial transaction survives.
- States:
  - IDLE: no pending write-back.
  - MCP: waiting for a multi-cycle result.
  - WB: write-back pending.
- in_ready (combinational):
  - IDLE: in_ready = !alu_mcp.
  - MCP: in_ready = (count==0).
  - WB: in_ready = wb_ready && !alu_mcp.
- in_ready never depends combinationally on in_valid.
- Entering MCP:
  - From IDLE, or from WB while wb_ready, when in_valid && alu_mcp.
  - Load count = MCP_EXTRA-1. busy is high while in MCP.
  - Upstream holds inputs stable, since in_ready is low. Each cycle count decrements; at count==0 in_ready rises and capture occurs on that edge.
  - Total: a multi-cycle op is captured MCP_EXTRA+1 cycles after in_valid first rises with alu_mcp set.
  - alu_mcp is ignored while in MCP.
  - If in_valid drops during MCP, return to IDLE with no capture. This is an upstream flush.
- Capture (in_valid && in_ready):
  - Register alu_dout to wb_data, plus rdest, we_req, and is_djnz && alu_qnzout.
  - Set wb_valid=1 and go to WB.
  - Latency for a single-cycle op: 1 cycle.
- Flag update, only on a capture edge with flags_en=1:
  - flag_c = alu_cout, flag_v = alu_vout.
  - flag_z = (alu_dout==32'h0), flag_s = alu_dout[31].
  - The new flags are visible in the cycle after capture, so a back-to-back dependent op sees them.
  - With flags_en=0, all flags hold.
- WB state:
  - wb_valid and all wb_* outputs hold stable until wb_ready.
  - On wb_ready with a new capture in the same cycle: stay in WB with the new data, giving throughput of 1 per cycle.
  - On wb_ready without a capture: go to IDLE with wb_valid=0.
  - On wb_ready with in_valid && alu_mcp: go to MCP with wb_valid=0.
  - Without wb_ready: in_ready is low and the flags hold.
- wb_data is unmodified and full 32 bits. Every opcode is handled identically.
- djnz_taken is meaningful only while wb_valid=1; it is 0 otherwise.

Test Plan:
- Reset, then ADD result 32'h0000_0000 with cout=1, vout=0, flags_en=1, wb_ready=1 -> one cycle later wb_valid=1, wb_data=0, flag_c=1, flag_z=1, flag_s=0, flag_v=0; next cycle wb_valid=0.
- Single-cycle ops on 3 consecutive cycles (data 1, 2, 3) with wb_ready=1 -> wb_data shows 1, 2, 3 on consecutive cycles with no bubbles; in_ready stays high.
- wb_ready=0 for 4 cycles with a second op queued -> wb_data holds the first value, in_ready=0, flags unchanged; after wb_ready rises, the second op is captured on the same edge.
- MCP_EXTRA=2, MUL with alu_mcp=1, result 32'h0001_0000 -> busy high 2 cycles, in_ready high only in the 2nd MCP cycle, wb_valid rises 3 cycles after in_valid, wb_data=32'h0001_0000.
- DJNZ with is_djnz=1, alu_qnzout=1, then alu_qnzout=0 -> djnz_taken=1 then 0, aligned with wb_valid; flags unchanged when flags_en=0.
- Assert reset_b low mid-MCP (count=1) and again during a held WB -> outputs go to 0 immediately, independent of clk; the next instruction after release follows IDLE timing.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Execute/write-back register behind the combinational alu: captures results,
// owns the C/V/Z/S flags and sequences multi-cycle ops ahead of write-back.
module alu_wb_stage #(
  parameter int unsigned MCP_EXTRA = 2,
  parameter int unsigned RDEST_W   = 4
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        alu_dout,
  input  logic               alu_cout,
  input  logic               alu_vout,
  input  logic               alu_qnzout,
  input  logic               alu_mcp,
  input  logic [RDEST_W-1:0] rdest,
  input  logic               we_req,
  input  logic               flags_en,
  input  logic               is_djnz,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [31:0]        wb_data,
  output logic [RDEST_W-1:0] wb_rdest,
  output logic               wb_we,
  output logic               djnz_taken,
  output logic               flag_c,
  output logic               flag_v,
  output logic               flag_z,
  output logic               flag_s,
  output logic               busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MCP_EXTRA - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MCP  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic               wb_valid_nx, wb_we_nx, djnz_taken_nx, busy_nx;
  logic [31:0]        wb_data_nx;
  logic [RDEST_W-1:0] wb_rdest_nx;
  logic               flag_c_nx, flag_v_nx, flag_z_nx, flag_s_nx;
  logic               capture;

  // Upstream handshake; deliberately independent of in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE: in_ready = !alu_mcp;
      ST_MCP:  in_ready = (count == '0);
      ST_WB:   in_ready = wb_ready && !alu_mcp;
      default: in_ready = 1'b0;
    endcase
  end

  assign capture = in_valid && in_ready;

  // Next-state and next-value logic for every register.
  always_comb begin
    state_nx      = state;
    count_nx      = count;
    wb_valid_nx   = wb_valid;
    wb_data_nx    = wb_data;
    wb_rdest_nx   = wb_rdest;
    wb_we_nx      = wb_we;
    djnz_taken_nx = djnz_taken;
    flag_c_nx     = flag_c;
    flag_v_nx     = flag_v;
    flag_z_nx     = flag_z;
    flag_s_nx     = flag_s;

    case (state)
      ST_IDLE: begin
        if (in_valid && alu_mcp) begin
          state_nx = ST_MCP;
          count_nx = CNT_LOAD;
        end
      end
      ST_MCP: begin
        // Dropping in_valid while waiting is an upstream flush.
        if (!in_valid) begin
          state_nx = ST_IDLE;
          count_nx = '0;
        end else if (count != '0) begin
          count_nx = count - CNT_W'(1);
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_valid_nx   = 1'b0;
          djnz_taken_nx = 1'b0;
          if (in_valid && alu_mcp) begin
            state_nx = ST_MCP;
            count_nx = CNT_LOAD;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        count_nx = '0;
      end
    endcase

    // A capture overrides the transitions above and lands in WB.
    if (capture) begin
      state_nx      = ST_WB;
      count_nx      = '0;
      wb_valid_nx   = 1'b1;
      wb_data_nx    = alu_dout;
      wb_rdest_nx   = rdest;
      wb_we_nx      = we_req;
      djnz_taken_nx = is_djnz && alu_qnzout;
      if (flags_en) begin
        flag_c_nx = alu_cout;
        flag_v_nx = alu_vout;
        flag_z_nx = (alu_dout == 32'h0);
        flag_s_nx = alu_dout[31];
      end
    end

    busy_nx = (state_nx == ST_MCP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= ST_IDLE;
      count      <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rdest   <= '0;
      wb_we      <= 1'b0;
      djnz_taken <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      flag_z     <= 1'b0;
      flag_s     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      wb_valid   <= wb_valid_nx;
      wb_data    <= wb_data_nx;
      wb_rdest   <= wb_rdest_nx;
      wb_we      <= wb_we_nx;
      djnz_taken <= djnz_taken_nx;
      flag_c     <= flag_c_nx;
      flag_v     <= flag_v_nx;
      flag_z     <= flag_z_nx;
      flag_s     <= flag_s_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: vector table for single-cycle ops plus
// hand sequences for stall, multi-cycle, flush and async reset.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        in_valid, in_ready;
  logic [31:0] alu_dout;
  logic        alu_cout, alu_vout, alu_qnzout, alu_mcp;
  logic [3:0]  rdest;
  logic        we_req, flags_en, is_djnz;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rdest;
  logic        wb_we, djnz_taken;
  logic        flag_c, flag_v, flag_z, flag_s, busy;

  int total  = 0;
  int passed = 0;

  alu_wb_stage #(.MCP_EXTRA(2), .RDEST_W(4)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_ready(in_ready),
    .alu_dout(alu_dout), .alu_cout(alu_cout), .alu_vout(alu_vout),
    .alu_qnzout(alu_qnzout), .alu_mcp(alu_mcp), .rdest(rdest),
    .we_req(we_req), .flags_en(flags_en), .is_djnz(is_djnz),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rdest(wb_rdest), .wb_we(wb_we), .djnz_taken(djnz_taken),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_s(flag_s),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] dout;
    logic        cout, vout, qnz, djnz, fe, we;
    logic [3:0]  rd;
    logic [31:0] e_data;
    logic        e_djnz, e_c, e_v, e_z, e_s;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic c, input logic vo,
                       input logic mcp, input logic fe, input logic [3:0] rd);
    in_valid = v; alu_dout = d; alu_cout = c; alu_vout = vo; alu_mcp = mcp;
    flags_en = fe; rdest = rd; we_req = 1'b1; is_djnz = 1'b0; alu_qnzout = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic [3:0] exp_cvzs);
    chk(name, 32'({flag_c, flag_v, flag_z, flag_s}), 32'(exp_cvzs));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({name, "_wb_data"}, wb_data, 32'd0);
    chk({name, "_wb_rdest"}, 32'(wb_rdest), 32'd0);
    chk({name, "_wb_we"}, 32'(wb_we), 32'd0);
    chk({name, "_djnz"}, 32'(djnz_taken), 32'd0);
    chk_flags({name, "_flags"}, 4'b0000);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    //           dout          c  v  q  dj fe we rd    e_data       edj c  v  z  s
    vecs[0] = '{32'h0000_0000, 1, 0, 0, 0, 1, 1, 4'd1, 32'h0000_0000, 0, 1, 0, 1, 0};
    vecs[1] = '{32'h0000_0001, 0, 0, 0, 0, 1, 1, 4'd2, 32'h0000_0001, 0, 0, 0, 0, 0};
    vecs[2] = '{32'h0000_0002, 0, 1, 0, 0, 1, 1, 4'd3, 32'h0000_0002, 0, 0, 1, 0, 0};
    vecs[3] = '{32'h0000_0003, 1, 0, 0, 0, 0, 1, 4'd4, 32'h0000_0003, 0, 0, 1, 0, 0};
    vecs[4] = '{32'h8000_0000, 1, 1, 0, 0, 1, 1, 4'd5, 32'h8000_0000, 0, 1, 1, 0, 1};
    vecs[5] = '{32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0, 4'd6, 32'hFFFF_FFFF, 1, 1, 1, 0, 1};
    vecs[6] = '{32'h0000_0000, 0, 0, 0, 1, 0, 0, 4'd7, 32'h0000_0000, 0, 1, 1, 0, 1};
    vecs[7] = '{32'h0000_0000, 0, 0, 1, 0, 1, 1, 4'hF, 32'h0000_0000, 0, 0, 0, 1, 0};

    reset_b = 1'b0; wb_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #22;
    chk_all_zero("reset");
    reset_b = 1'b1;
    tick();

    // First ADD then idle: wb_valid pulses for exactly one cycle.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
    tick();
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_data", wb_data, 32'h0);
    chk_flags("add_flags", 4'b1010);
    in_valid = 1'b0;
    tick();
    chk("add_wb_valid_drop", 32'(wb_valid), 32'd0);

    // Back-to-back single-cycle ops from the table.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].dout, vecs[i].cout, vecs[i].vout, 1'b0, vecs[i].fe, vecs[i].rd);
      we_req = vecs[i].we; is_djnz = vecs[i].djnz; alu_qnzout = vecs[i].qnz;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].e_data);
      chk($sformatf("vec%0d_wb_rdest", i), 32'(wb_rdest), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_wb_we", i), 32'(wb_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_djnz", i), 32'(djnz_taken), 32'(vecs[i].e_djnz));
      chk_flags($sformatf("vec%0d_flags", i),
                {vecs[i].e_c, vecs[i].e_v, vecs[i].e_z, vecs[i].e_s});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk("tbl_end_wb_valid", 32'(wb_valid), 32'd0);
    chk("tbl_end_djnz", 32'(djnz_taken), 32'd0);

    // Downstream stall holds the first result while a second op waits.
    drive(1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    chk("stall_first_data", wb_data, 32'hAAAA_AAAA);
    drive(1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("stall%0d_wb_data", i), wb_data, 32'hAAAA_AAAA);
      chk($sformatf("stall%0d_wb_rdest", i), 32'(wb_rdest), 32'd3);
      chk_flags($sformatf("stall%0d_flags", i), 4'b1001);
    end
    wb_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("stall_second_data", wb_data, 32'hBBBB_BBBB);
    chk("stall_second_rdest", 32'(wb_rdest), 32'd4);
    chk_flags("stall_second_flags", 4'b0001);
    in_valid = 1'b0;
    tick();

    // Multi-cycle op from IDLE, then WB straight into another MCP.
    drive(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
    #1;
    chk("mcp_in_ready_c0", 32'(in_ready), 32'd0);
    tick();
    chk("mcp_busy_c1", 32'(busy), 32'd1);
    chk("mcp_in_ready_c1", 32'(in_ready), 32'd0);
    chk("mcp_wb_valid_c1", 32'(wb_valid), 32'd0);
    tick();
    chk("mcp_busy_c2", 32'(busy), 32'd1);
    chk("mcp_in_ready_c2", 32'(in_ready), 32'd1);
    chk("mcp_wb_valid_c2", 32'(wb_valid), 32'd0);
    tick();
    chk("mcp_busy_c3", 32'(busy), 32'd0);
    chk("mcp_wb_valid_c3", 32'(wb_valid), 32'd1);
    chk("mcp_wb_data_c3", wb_data, 32'h0001_0000);
    chk("mcp_wb_rdest_c3", 32'(wb_rdest), 32'd5);
    chk_flags("mcp_flags_hold", 4'b0001);
    drive(1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
    #1;
    chk("wb2mcp_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("wb2mcp_busy", 32'(busy), 32'd1);
    chk("wb2mcp_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    tick();
    chk("wb2mcp_wb_data", wb_data, 32'h0002_0000);
    chk("wb2mcp_wb_valid_cap", 32'(wb_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // Flush: in_valid drops while waiting, nothing is captured.
    drive(1'b1, 32'h0003_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
    tick();
    chk("flush_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("flush_busy_drop", 32'(busy), 32'd0);
    chk("flush_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    chk("flush_wb_valid_later", 32'(wb_valid), 32'd0);

    // Async reset mid-MCP with count==1 and non-zero flags.
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
    tick();
    drive(1'b1, 32'h0004_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    tick();
    chk("rst_mcp_pre_busy", 32'(busy), 32'd1);
    chk_flags("rst_mcp_pre_flags", 4'b1001);
    #2 reset_b = 1'b0;
    #1;
    chk_all_zero("rst_mcp");
    in_valid = 1'b0;
    #3 reset_b = 1'b1;
    tick();
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("post_rst_wb_valid", 32'(wb_valid), 32'd1);
    chk("post_rst_wb_data", wb_data, 32'h1234_5678);

    // Async reset while a write-back is held.
    wb_ready = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_wb_pre_hold", 32'(wb_valid), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    chk_all_zero("rst_wb");
    #3 reset_b = 1'b1;
    wb_ready = 1'b1;
    tick();
    chk("rst_wb_after_valid", 32'(wb_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
